// File: rtl/demux_pkg.sv
// Shared constants and lane-index type for the registered 1:4 demultiplexer.
package demux_pkg;

    localparam int NUM_LANES = 4;
    localparam int SEL_W     = 2;

    typedef logic [SEL_W-1:0] lane_idx_t;

    // Round-robin successor; the natural 2-bit wrap gives 3 -> 0.
    function automatic lane_idx_t next_lane(input lane_idx_t idx);
        return idx + lane_idx_t'(1);
    endfunction

endpackage

// File: rtl/demux_lane_reg.sv
// Single-entry holding register for one output lane with a valid/ready handshake.
module demux_lane_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             ready,
    input  logic [WIDTH-1:0] d,
    output logic             valid,
    output logic [WIDTH-1:0] q
);

    // A load wins over a same-cycle drain so back-to-back traffic has no bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_1_4_reg.sv
// Registered 1:4 demultiplexer: steers one input stream to one of four lanes,
// chosen by an explicit select or by a strict round-robin pointer.
module demux_1_4_reg
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           D,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [SEL_W-1:0]           S,
    input  logic                       auto_mode,
    output logic [NUM_LANES*WIDTH-1:0] Y,
    output logic [NUM_LANES-1:0]       out_valid,
    input  logic [NUM_LANES-1:0]       out_ready,
    output logic [SEL_W-1:0]           rr_ptr
);

    lane_idx_t            rr_q;
    lane_idx_t            tgt;
    logic                 accept;
    logic [NUM_LANES-1:0] load;

    assign tgt      = auto_mode ? rr_q : lane_idx_t'(S);
    assign in_ready = ~out_valid[tgt] | out_ready[tgt];
    assign accept   = in_valid & in_ready & rst_n;
    assign rr_ptr   = rr_q;

    // The pointer never skips a full lane: it only moves when a word is taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_q <= '0;
        end else if (accept && auto_mode) begin
            rr_q <= next_lane(rr_q);
        end
    end

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        assign load[k] = accept && (tgt == lane_idx_t'(k));

        demux_lane_reg #(
            .WIDTH (WIDTH)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (load[k]),
            .ready (out_ready[k]),
            .d     (D),
            .valid (out_valid[k]),
            .q     (Y[k*WIDTH +: WIDTH])
        );
    end

endmodule

// File: tb/tb_demux_1_4_reg.sv
// Directed and randomized self-checking bench for demux_1_4_reg.
module tb_demux_1_4_reg;

    logic        clk;
    logic        rst_n;
    logic [7:0]  D;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  S;
    logic        auto_mode;
    logic [31:0] Y;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [1:0]  rr_ptr;

    int checks   = 0;
    int failures = 0;

    demux_1_4_reg #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .D         (D),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .S         (S),
        .auto_mode (auto_mode),
        .Y         (Y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rr_ptr    (rr_ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] lane(input int k);
        return Y[k*8 +: 8];
    endfunction

    // Inputs are driven 1 time unit after the rising edge, outputs sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_flush();
        in_valid  = 1'b0;
        out_ready = 4'hF;
        tick();
        out_ready = 4'h0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; D = 8'h00; S = 2'd0;
        auto_mode = 1'b0; out_ready = 4'h0;
        tick(); tick();
        checks++;
        if (out_valid !== 4'b0000 || Y !== 32'h0 || rr_ptr !== 2'd0) begin
            failures++;
            $display("[TB] FAIL reset_state: out_valid=%b Y=%h rr_ptr=%0d, want 0000/0/0", out_valid, Y, rr_ptr);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_explicit_select();
        auto_mode = 1'b0; S = 2'd2; D = 8'hA5; in_valid = 1'b1; out_ready = 4'h0;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 4'b0100 || lane(2) !== 8'hA5) begin
            failures++;
            $display("[TB] FAIL sel_load: out_valid=%b lane2=%h, want 0100/a5", out_valid, lane(2));
        end
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL sel_full_ready: in_ready=%b, want 0", in_ready);
        end
        S = 2'd1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL sel_empty_ready: in_ready=%b, want 1", in_ready);
        end
        idle_flush();
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [5];
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
        words[3] = 8'h44; words[4] = 8'h55;
        auto_mode = 1'b1; out_ready = 4'hF;
        for (int i = 0; i < 5; i++) begin
            D = words[i]; in_valid = 1'b1;
            #1;
            checks++;
            if (in_ready !== 1'b1 || rr_ptr !== 2'(i % 4)) begin
                failures++;
                $display("[TB] FAIL b2b_pre%0d: in_ready=%b rr_ptr=%0d, want 1/%0d", i, in_ready, rr_ptr, i % 4);
            end
            tick();
            checks++;
            if (out_valid[i % 4] !== 1'b1 || lane(i % 4) !== words[i]) begin
                failures++;
                $display("[TB] FAIL b2b_lane%0d: valid=%b data=%h, want 1/%h", i % 4, out_valid[i % 4], lane(i % 4), words[i]);
            end
        end
        checks++;
        if (rr_ptr !== 2'd1) begin
            failures++;
            $display("[TB] FAIL b2b_final_ptr: rr_ptr=%0d, want 1", rr_ptr);
        end
        idle_flush();
    endtask

    task automatic test_stall();
        auto_mode = 1'b0; S = 2'd1; D = 8'h66; in_valid = 1'b1; out_ready = 4'h0;
        tick();
        auto_mode = 1'b1; D = 8'h77;
        #1;
        checks++;
        if (in_ready !== 1'b0 || rr_ptr !== 2'd1) begin
            failures++;
            $display("[TB] FAIL stall_block: in_ready=%b rr_ptr=%0d, want 0/1", in_ready, rr_ptr);
        end
        tick();
        checks++;
        if (rr_ptr !== 2'd1 || lane(1) !== 8'h66 || out_valid !== 4'b0010) begin
            failures++;
            $display("[TB] FAIL stall_hold: rr_ptr=%0d lane1=%h out_valid=%b, want 1/66/0010", rr_ptr, lane(1), out_valid);
        end
        out_ready = 4'b0010;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL stall_release: in_ready=%b, want 1", in_ready);
        end
        tick();
        in_valid = 1'b0; out_ready = 4'h0;
        checks++;
        if (lane(1) !== 8'h77 || out_valid[1] !== 1'b1 || rr_ptr !== 2'd2) begin
            failures++;
            $display("[TB] FAIL stall_after: lane1=%h valid=%b rr_ptr=%0d, want 77/1/2", lane(1), out_valid[1], rr_ptr);
        end
        idle_flush();
    endtask

    task automatic test_overwrite();
        auto_mode = 1'b0; S = 2'd3; D = 8'h3C; in_valid = 1'b1; out_ready = 4'h0;
        tick();
        D = 8'h7E; out_ready = 4'b1000;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ovw_ready: in_ready=%b, want 1", in_ready);
        end
        tick();
        in_valid = 1'b0; out_ready = 4'h0;
        checks++;
        if (lane(3) !== 8'h7E || out_valid !== 4'b1000) begin
            failures++;
            $display("[TB] FAIL ovw_no_bubble: lane3=%h out_valid=%b, want 7e/1000", lane(3), out_valid);
        end
        idle_flush();
    endtask

    task automatic test_mid_reset();
        auto_mode = 1'b0; out_ready = 4'h0; in_valid = 1'b1;
        S = 2'd0; D = 8'hA0; tick();
        S = 2'd2; D = 8'hC2; tick();
        checks++;
        if (out_valid !== 4'b0101) begin
            failures++;
            $display("[TB] FAIL mrst_setup: out_valid=%b, want 0101", out_valid);
        end
        rst_n = 1'b0; auto_mode = 1'b1; S = 2'd1; D = 8'hFF;
        tick();
        rst_n = 1'b1; in_valid = 1'b0;
        checks++;
        if (out_valid !== 4'b0000 || Y !== 32'h0 || rr_ptr !== 2'd0) begin
            failures++;
            $display("[TB] FAIL mrst_clear: out_valid=%b Y=%h rr_ptr=%0d, want 0000/0/0", out_valid, Y, rr_ptr);
        end
    endtask

    task automatic test_mode_toggle();
        logic [1:0] exp_ptr [3];
        logic       modes   [3];
        exp_ptr[0] = 2'd1; exp_ptr[1] = 2'd1; exp_ptr[2] = 2'd2;
        modes[0] = 1'b1; modes[1] = 1'b0; modes[2] = 1'b1;
        out_ready = 4'hF; S = 2'd3;
        for (int i = 0; i < 3; i++) begin
            auto_mode = modes[i]; D = 8'(8'h90 + i); in_valid = 1'b1;
            tick();
            checks++;
            if (rr_ptr !== exp_ptr[i]) begin
                failures++;
                $display("[TB] FAIL toggle_ptr%0d: rr_ptr=%0d, want %0d", i, rr_ptr, exp_ptr[i]);
            end
        end
        idle_flush();
    endtask

    task automatic test_random_scoreboard();
        logic       mv [4];
        logic [7:0] my [4];
        logic [1:0] mrr;
        logic [1:0] tgt;
        logic       exp_ready;
        int         sent, drained, parked;
        for (int k = 0; k < 4; k++) begin
            mv[k] = 1'b0; my[k] = 8'h00;
        end
        mrr = 2'd2; sent = 0; drained = 0;
        for (int c = 0; c < 1000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            D         = 8'($urandom);
            S         = 2'($urandom);
            auto_mode = 1'($urandom_range(0, 1));
            out_ready = 4'($urandom);
            #1;
            tgt = auto_mode ? mrr : S;
            exp_ready = !mv[tgt] || out_ready[tgt];
            checks++;
            if (in_ready !== exp_ready) begin
                failures++;
                $display("[TB] FAIL rnd_ready c%0d: in_ready=%b, want %b", c, in_ready, exp_ready);
            end
            for (int k = 0; k < 4; k++) begin
                if (mv[k] && out_ready[k]) begin
                    drained++;
                    mv[k] = 1'b0;
                end
            end
            if (in_valid && exp_ready) begin
                sent++;
                mv[tgt] = 1'b1;
                my[tgt] = D;
                if (auto_mode) mrr = mrr + 2'd1;
            end
            tick();
            checks++;
            if (out_valid !== {mv[3], mv[2], mv[1], mv[0]} || rr_ptr !== mrr) begin
                failures++;
                $display("[TB] FAIL rnd_state c%0d: out_valid=%b rr_ptr=%0d, want %b/%0d", c, out_valid, rr_ptr, {mv[3], mv[2], mv[1], mv[0]}, mrr);
            end
            for (int k = 0; k < 4; k++) begin
                if (mv[k]) begin
                    checks++;
                    if (lane(k) !== my[k]) begin
                        failures++;
                        $display("[TB] FAIL rnd_data c%0d lane%0d: got %h, want %h", c, k, lane(k), my[k]);
                    end
                end
            end
        end
        parked = 0;
        for (int k = 0; k < 4; k++) if (mv[k]) parked++;
        checks++;
        if (sent !== drained + parked) begin
            failures++;
            $display("[TB] FAIL rnd_exactly_once: sent=%0d, drained+parked=%0d", sent, drained + parked);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_explicit_select();
        test_back_to_back();
        test_stall();
        test_overwrite();
        test_mid_reset();
        test_mode_toggle();
        test_random_scoreboard();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
